// File: rtl/lut_ram_loader_pkg.sv
// lut_ram_loader_pkg: state/mode enums and width helpers shared by the LUT RAM loader.
package lut_ram_loader_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, FILL, VERIFY, DONE} state_t;
  typedef enum logic {MODE_LOAD, MODE_FILL} mode_t;
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int len_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/lut_ram_loader.sv
// lut_ram_loader: LUT RAM write-port feeder (stream LOAD or constant FILL).
// LUT_RAM_LOADER_READBACK_EN adds a post-write VERIFY pass with rd_addr/rd_data/mismatch ports.
module lut_ram_loader
  import lut_ram_loader_pkg::*;
#(
  parameter int LUT_WIDTH = 32,
  parameter int LUT_DEPTH = 256,
  localparam int ADDR_W = addr_w(LUT_DEPTH),
  localparam int LEN_W = len_w(LUT_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef LUT_RAM_LOADER_READBACK_EN
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [LUT_WIDTH-1:0] rd_data,
  output logic                 mismatch,
`endif
  input  logic                 start,
  input  logic                 mode,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [LEN_W-1:0]     length,
  input  logic [LUT_WIDTH-1:0] fill_data,
  input  logic                 in_valid,
  input  logic [LUT_WIDTH-1:0] in_data,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [LUT_WIDTH-1:0] wr_data,
  output logic                 busy,
  output logic                 done
);
  state_t state, next;
  logic [LEN_W-1:0] len_q, count;
  logic [ADDR_W-1:0] cur_addr;
  logic [LUT_WIDTH-1:0] fill_q;
  logic accept, fire, last;
  function automatic logic [ADDR_W-1:0] inc(input logic [ADDR_W-1:0] a);
    return a == ADDR_W'(LUT_DEPTH - 1) ? '0 : a + 1'b1;
  endfunction
  // a start in the done cycle is treated as still belonging to the finished command
  assign accept = state == IDLE && start && !done;
  assign in_ready = state == LOAD && count < len_q;
  assign fire = (state == FILL && count < len_q) || (in_ready && in_valid);
  assign last = count == len_q - 1'b1;
  assign busy = state != IDLE;
`ifdef LUT_RAM_LOADER_READBACK_EN
  localparam state_t WR_END = VERIFY;
  logic [ADDR_W-1:0] base_q;
  mode_t mode_q;
  logic [LUT_WIDTH-1:0] shadow [LUT_DEPTH];
  logic [LUT_WIDTH-1:0] exp_q;
  logic cmp_valid, issue;
  // first VERIFY cycle still carries the last write; wait it out to avoid read-during-write
  assign issue = state == VERIFY && !wr_en;
  assign rd_addr = cur_addr;
  always_ff @(posedge clk)
    if (in_ready && in_valid) shadow[cur_addr] <= in_data;
`else
  localparam state_t WR_END = DONE;
`endif
  always_comb begin
    next = state;
    case (state)
      IDLE: next = !accept ? IDLE : length == '0 ? DONE : mode_t'(mode) == MODE_FILL ? FILL : LOAD;
      LOAD, FILL: next = fire && last ? WR_END : state;
`ifdef LUT_RAM_LOADER_READBACK_EN
      VERIFY: next = issue && last ? DONE : VERIFY;
`endif
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      len_q <= '0;
      count <= '0;
      cur_addr <= '0;
      fill_q <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done <= 1'b0;
`ifdef LUT_RAM_LOADER_READBACK_EN
      base_q <= '0;
      mode_q <= MODE_LOAD;
      exp_q <= '0;
      cmp_valid <= 1'b0;
      mismatch <= 1'b0;
`endif
    end else begin
      state <= next;
      done <= state == DONE;
      wr_en <= fire;
      if (accept) begin
        len_q <= length;
        fill_q <= fill_data;
        cur_addr <= base_addr;
        count <= '0;
      end
      if (fire) begin
        wr_addr <= cur_addr;
        wr_data <= state == FILL ? fill_q : in_data;
        cur_addr <= inc(cur_addr);
        count <= count + 1'b1;
      end
`ifdef LUT_RAM_LOADER_READBACK_EN
      if (accept) begin
        base_q <= base_addr;
        mode_q <= mode_t'(mode);
      end
      if (fire && last) begin
        cur_addr <= base_q;
        count <= '0;
      end
      if (issue) begin
        cur_addr <= inc(cur_addr);
        count <= count + 1'b1;
      end
      cmp_valid <= issue;
      exp_q <= mode_q == MODE_FILL ? fill_q : shadow[cur_addr];
      mismatch <= accept ? 1'b0 : mismatch | (cmp_valid && rd_data != exp_q);
`endif
    end
  end
endmodule

// File: tb/tb_lut_ram_loader.sv
// tb_lut_ram_loader: scoreboard bench for lut_ram_loader (LUT_RAM_LOADER_READBACK_EN adds a RAM model).
module tb_lut_ram_loader;
  localparam int W = 32, D = 256, AW = 8, LW = 9;
  typedef struct packed {logic [AW-1:0] a; logic [W-1:0] d;} wr_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0, in_valid = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] length = '0;
  logic [W-1:0] fill_data = '0, in_data = '0;
  logic in_ready, wr_en, busy, done;
  logic [AW-1:0] wr_addr;
  logic [W-1:0] wr_data;
  wr_t sb[$];
  wr_t e;
  int vectors = 0, errors = 0, cyc = 0, wr_total = 0, done_cnt = 0, busy_cnt = 0, last_wr = 0;
  bit had_wr = 1'b0, exp_mm = 1'b0;
`ifdef LUT_RAM_LOADER_READBACK_EN
  logic [AW-1:0] rd_addr;
  logic [W-1:0] rd_data = '0;
  logic mismatch;
  logic [W-1:0] ram [D];
  int bad_addr = -1;
  always @(posedge clk) begin
    if (wr_en) ram[wr_addr] <= wr_data;
    rd_data <= int'(rd_addr) == bad_addr ? ~ram[rd_addr] : ram[rd_addr];
  end
`endif
  lut_ram_loader #(.LUT_WIDTH(W), .LUT_DEPTH(D)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef LUT_RAM_LOADER_READBACK_EN
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .mismatch(mismatch),
`endif
    .start(start),
    .mode(mode),
    .base_addr(base_addr),
    .length(length),
    .fill_data(fill_data),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    if (busy) busy_cnt++;
    if (wr_en) begin
      wr_total++;
      last_wr = cyc;
      check("wr_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("wr_addr", wr_addr, e.a);
        check("wr_data", wr_data, e.d);
      end
    end
    if (done) begin
      done_cnt++;
      check("busy_at_done", busy, 0);
      check("sb_drained", sb.size(), 0);
      if (!had_wr) check("busy_len0", busy_cnt <= 1, 1);
`ifdef LUT_RAM_LOADER_READBACK_EN
      check("mismatch", mismatch, exp_mm);
`else
      if (had_wr) check("done_latency", cyc - last_wr, 1);
`endif
    end
  end
  task automatic run(input bit m, input int base, input int len, input logic [W-1:0] fd, input logic [7:0] gaps);
    int n, d0;
    bit rdy_chk;
    n = 0;
    d0 = done_cnt;
    rdy_chk = 1'b0;
    @(posedge clk); #1;
    had_wr = len != 0;
    busy_cnt = 0;
    start = 1'b1;
    mode = m;
    base_addr = AW'(base);
    length = LW'(len);
    fill_data = fd;
    if (m) for (int i = 0; i < len; i++) sb.push_back(wr_t'{AW'((base + i) % D), fd});
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < 1000 && done_cnt == d0; t++) begin
      in_valid = !m && gaps[t % 8];
      in_data = $urandom;
      @(negedge clk);
      if (m && t == 0) check("in_ready_fill", in_ready, 0);
      if (in_valid && in_ready) begin
        sb.push_back(wr_t'{AW'((base + n) % D), in_data});
        n++;
      end else if (!m && len != 0 && n == len && !rdy_chk) begin
        check("in_ready_end", in_ready, 0);
        rdy_chk = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("done_seen", done_cnt - d0, 1);
  endtask
  initial begin
    int w0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    rst_n = 1'b1;
    run(1'b1, 10, 4, 32'hDEAD_BEEF, 8'hFF);
    run(1'b0, 0, 3, '0, 8'b1111_1101);
    run(1'b0, 254, 4, '0, 8'hFF);
    run(1'b0, 17, 0, '0, 8'hFF);
    run(1'b0, 128, 20, '0, 8'b1011_0110);
    run(1'b1, 5, 256, 32'h5A5A_0F0F, 8'hFF);
    w0 = wr_total;
    @(posedge clk); #1;
    had_wr = 1'b1;
    start = 1'b1;
    mode = 1'b1;
    base_addr = 8'd100;
    length = 9'd8;
    fill_data = 32'hCAFE_0001;
    for (int i = 0; i < 8; i++) sb.push_back(wr_t'{AW'(100 + i), 32'hCAFE_0001});
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    mode = 1'b0;
    base_addr = 8'd50;
    length = 9'd2;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < 50 && wr_total < w0 + 3; t++) begin
      @(negedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_wr_en", wr_en, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_wr_addr", wr_addr, 0);
    check("abort_wr_data", wr_data, 0);
    sb.delete();
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("abort_writes", wr_total - w0, 3);
    check("abort_idle", busy, 0);
`ifdef LUT_RAM_LOADER_READBACK_EN
    bad_addr = 62;
    exp_mm = 1'b1;
    run(1'b1, 60, 5, 32'h1234_5678, 8'hFF);
    repeat (2) @(posedge clk);
    #1;
    check("mismatch_sticky", mismatch, 1);
    bad_addr = -1;
    exp_mm = 1'b0;
    run(1'b1, 60, 5, 32'h1234_5678, 8'hFF);
    run(1'b0, 30, 6, '0, 8'b0110_1011);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
